// File: rtl/harvos_pkg.sv
// Shared types for the HarvOS memory arbiter.
// States and policy selectors used by the arbiter and its picker.
package harvos_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   localparam logic ARB_FIXED = 1'b0;
   localparam logic ARB_RR    = 1'b1;

endpackage

// File: rtl/harvos_arb_pick.sv
// Combinational winner picker: fixed priority with a
// starvation override, or round-robin after rr_ptr.
module harvos_arb_pick
   import harvos_pkg::*;
#(
   parameter int N  = 3,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] rr_ptr,
   input  logic          mode,
   input  logic [N-1:0]  starve_vec,
   output logic [IW-1:0] idx,
   output logic [N-1:0]  gnt,
   output logic          valid
);

   logic [N-1:0] starved;
   logic [N-1:0] one;

   assign starved = req & starve_vec;
   assign one     = {{(N-1){1'b0}}, 1'b1};

   always_comb begin
      logic found;
      int   j;
      found = 1'b0;
      j     = 0;
      idx   = '0;
      valid = |req;
      if (mode == ARB_RR) begin
         for (int k = 1; k <= N; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
               idx   = IW'(j);
               found = 1'b1;
            end
         end
      end else if (|starved) begin
         for (int i = 0; i < N; i++) begin
            if (!found && starved[i]) begin
               idx   = IW'(i);
               found = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
               idx   = IW'(i);
               found = 1'b1;
            end
         end
      end
      gnt = valid ? (one << idx) : '0;
   end

endmodule

// File: rtl/harvos_mem_arbiter.sv
// N-master arbiter for the shared RAM port with aging,
// single-outstanding owner tracking and response timeout.
module harvos_mem_arbiter
   import harvos_pkg::*;
#(
   parameter int N_MASTERS    = 3,
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int RR_EN        = 0,
   parameter int STARVE_LIMIT = 15,
   parameter int TIMEOUT      = 255
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_MASTERS-1:0]      m_req,
   input  logic [N_MASTERS-1:0]      m_we,
   input  logic [N_MASTERS*DW/8-1:0] m_be,
   input  logic [N_MASTERS*AW-1:0]   m_addr,
   input  logic [N_MASTERS*DW-1:0]   m_wdata,
   output logic [N_MASTERS-1:0]      m_gnt,
   output logic [DW-1:0]             m_rdata,
   output logic [N_MASTERS-1:0]      m_rvalid,
   output logic [N_MASTERS-1:0]      m_fault,
   output logic                      s_req,
   output logic                      s_we,
   output logic [DW/8-1:0]           s_be,
   output logic [AW-1:0]             s_addr,
   output logic [DW-1:0]             s_wdata,
   input  logic [DW-1:0]             s_rdata,
   input  logic                      s_rvalid,
   input  logic                      s_fault,
   output logic                      busy,
   output logic [$clog2(N_MASTERS)-1:0] owner_idx,
   output logic                      timeout_evt
);

   localparam int IW = $clog2(N_MASTERS);
   localparam int BW = DW / 8;
   localparam int SW = (STARVE_LIMIT > 0) ?
                       $clog2(STARVE_LIMIT + 1) : 1;
   localparam int TW = (TIMEOUT > 0) ?
                       $clog2(TIMEOUT + 1) : 1;
   localparam bit AGE_ON = (RR_EN == 0) &&
                           (STARVE_LIMIT > 0);

   arb_state_e          state_q, state_d;
   logic [IW-1:0]       owner_q, owner_d;
   logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic [SW-1:0]       age_q [N_MASTERS];
   logic [SW-1:0]       age_d [N_MASTERS];

   logic [N_MASTERS-1:0] req_ok;
   logic [N_MASTERS-1:0] starve;
   logic [N_MASTERS-1:0] pick_gnt;
   logic [IW-1:0]        pick_idx;
   logic                 pick_vld;
   logic                 expire;
   logic                 mode;

   // Requests are masked during reset so no grant can leak out.
   assign req_ok    = m_req & {N_MASTERS{rst_n}};
   assign mode      = (RR_EN != 0) ? ARB_RR : ARB_FIXED;
   assign busy      = (state_q == BUSY);
   assign owner_idx = owner_q;
   assign m_rdata   = s_rdata;
   assign expire    = (TIMEOUT > 0) &&
                      (timer_q == TW'(TIMEOUT - 1));

   harvos_arb_pick #(
      .N  (N_MASTERS),
      .IW (IW)
   ) u_pick (
      .req        (req_ok),
      .rr_ptr     (rr_ptr_q),
      .mode       (mode),
      .starve_vec (starve),
      .idx        (pick_idx),
      .gnt        (pick_gnt),
      .valid      (pick_vld)
   );

   always_comb begin
      for (int i = 0; i < N_MASTERS; i++) begin
         starve[i] = AGE_ON &&
                     (age_q[i] >= SW'(STARVE_LIMIT));
      end
   end

   // Counters run in BUSY as well; saturate at the limit.
   always_comb begin
      for (int i = 0; i < N_MASTERS; i++) begin
         age_d[i] = '0;
         if (AGE_ON && req_ok[i] && !m_gnt[i]) begin
            age_d[i] = starve[i] ? age_q[i] :
                       age_q[i] + 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      timer_d     = timer_q;
      m_gnt       = '0;
      m_rvalid    = '0;
      m_fault     = '0;
      timeout_evt = 1'b0;
      s_req       = 1'b0;
      s_we        = 1'b0;
      s_be        = '0;
      s_addr      = '0;
      s_wdata     = '0;
      unique case (state_q)
         IDLE: begin
            timer_d = '0;
            if (pick_vld) begin
               s_req    = 1'b1;
               s_we     = m_we[pick_idx];
               s_be     = m_be[pick_idx*BW +: BW];
               s_addr   = m_addr[pick_idx*AW +: AW];
               s_wdata  = m_wdata[pick_idx*DW +: DW];
               m_gnt    = pick_gnt;
               owner_d  = pick_idx;
               rr_ptr_d = pick_idx;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            if (s_rvalid) begin
               m_rvalid[owner_q] = 1'b1;
               m_fault[owner_q]  = s_fault;
               state_d           = IDLE;
            end else if (expire) begin
               m_rvalid[owner_q] = 1'b1;
               m_fault[owner_q]  = 1'b1;
               timeout_evt       = 1'b1;
               state_d           = IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         rr_ptr_q <= IW'(N_MASTERS - 1);
         timer_q  <= '0;
         for (int i = 0; i < N_MASTERS; i++) begin
            age_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         timer_q  <= timer_d;
         for (int i = 0; i < N_MASTERS; i++) begin
            age_q[i] <= age_d[i];
         end
      end
   end

endmodule

// File: tb/tb_harvos_mem_arbiter.sv
// Directed bench: a fixed-priority and a round-robin
// arbiter driven by the same masters and slave.
module tb_harvos_mem_arbiter;
   import harvos_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  m_req;
   logic [2:0]  m_we;
   logic [11:0] m_be;
   logic [95:0] m_addr;
   logic [95:0] m_wdata;
   logic [31:0] s_rdata;
   logic        s_rvalid;
   logic        s_fault;

   logic [2:0]  fx_gnt, fx_rvalid, fx_fault;
   logic [31:0] fx_rdata, fx_saddr, fx_swdata;
   logic [3:0]  fx_sbe;
   logic        fx_sreq, fx_swe, fx_busy, fx_tmo;
   logic [1:0]  fx_owner;

   logic [2:0]  rr_gnt, rr_rvalid, rr_fault;
   logic [31:0] rr_rdata, rr_saddr, rr_swdata;
   logic [3:0]  rr_sbe;
   logic        rr_sreq, rr_swe, rr_busy, rr_tmo;
   logic [1:0]  rr_owner;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   harvos_mem_arbiter #(
      .N_MASTERS(3), .AW(32), .DW(32), .RR_EN(0),
      .STARVE_LIMIT(4), .TIMEOUT(8)
   ) u_fix (
      .clk(clk), .rst_n(rst_n), .m_req(m_req),
      .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_gnt(fx_gnt),
      .m_rdata(fx_rdata), .m_rvalid(fx_rvalid),
      .m_fault(fx_fault), .s_req(fx_sreq),
      .s_we(fx_swe), .s_be(fx_sbe), .s_addr(fx_saddr),
      .s_wdata(fx_swdata), .s_rdata(s_rdata),
      .s_rvalid(s_rvalid), .s_fault(s_fault),
      .busy(fx_busy), .owner_idx(fx_owner),
      .timeout_evt(fx_tmo)
   );

   harvos_mem_arbiter #(
      .N_MASTERS(3), .AW(32), .DW(32), .RR_EN(1),
      .STARVE_LIMIT(4), .TIMEOUT(8)
   ) u_rr (
      .clk(clk), .rst_n(rst_n), .m_req(m_req),
      .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_gnt(rr_gnt),
      .m_rdata(rr_rdata), .m_rvalid(rr_rvalid),
      .m_fault(rr_fault), .s_req(rr_sreq),
      .s_we(rr_swe), .s_be(rr_sbe), .s_addr(rr_saddr),
      .s_wdata(rr_swdata), .s_rdata(s_rdata),
      .s_rvalid(s_rvalid), .s_fault(s_fault),
      .busy(rr_busy), .owner_idx(rr_owner),
      .timeout_evt(rr_tmo)
   );

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h",
                  tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   logic [2:0] rr_exp [4];
   logic [1:0] own_exp [4];
   logic [2:0] age_exp [4];

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rr_exp  = '{3'b001, 3'b010, 3'b100, 3'b001};
      own_exp = '{2'd0, 2'd1, 2'd2, 2'd0};
      age_exp = '{3'b001, 3'b001, 3'b100, 3'b001};
      rst_n    = 1'b0;
      m_req    = '0;
      m_we     = 3'b010;
      m_be     = {4'hF, 4'h3, 4'h1};
      m_addr   = {32'h3000, 32'h2000, 32'h1000};
      m_wdata  = {32'hC2C2, 32'hB1B1, 32'hA0A0};
      s_rdata  = 32'hDEAD_BEEF;
      s_rvalid = 1'b0;
      s_fault  = 1'b0;
      #3;
      check("rst_busy", fx_busy, 0);
      check("rst_owner", fx_owner, 0);
      check("rst_sreq", fx_sreq, 0);
      check("rst_saddr", fx_saddr, 0);
      check("rst_gnt", fx_gnt, 0);
      check("rst_rr_busy", rr_busy, 0);
      nxt();
      nxt();
      rst_n = 1'b1;

      for (int k = 0; k < 4; k++) begin
         nxt();
         m_req = 3'b111;
         s_rvalid = 1'b0;
         #2;
         check("rr_gnt", rr_gnt, rr_exp[k]);
         nxt();
         s_rvalid = 1'b1;
         if (k == 3) m_req = '0;
         #2;
         check("rr_owner", rr_owner, own_exp[k]);
         check("rr_rvalid", rr_rvalid, rr_exp[k]);
      end
      nxt();
      s_rvalid = 1'b0;
      #2;
      check("rr_idle", rr_busy, 0);
      check("fx_idle", fx_busy, 0);

      nxt();
      m_req = 3'b111;
      #2;
      check("fp_gnt", fx_gnt, 3'b001);
      check("fp_saddr", fx_saddr, 32'h1000);
      check("fp_sreq", fx_sreq, 1);
      nxt();
      m_req = '0;
      #2;
      check("fp_busy", fx_busy, 1);
      check("fp_sreq_b", fx_sreq, 0);
      check("fp_nogrant", fx_gnt, 0);
      nxt();
      s_rvalid = 1'b1;
      #2;
      check("fp_rvalid", fx_rvalid, 3'b001);
      check("fp_rdata", fx_rdata, 32'hDEAD_BEEF);
      check("fp_fault", fx_fault, 0);
      nxt();
      #2;
      check("spur_rvalid", fx_rvalid, 0);
      check("spur_busy", fx_busy, 0);

      for (int k = 0; k < 4; k++) begin
         nxt();
         m_req = 3'b101;
         s_rvalid = 1'b0;
         #2;
         check("age_gnt", fx_gnt, age_exp[k]);
         nxt();
         s_rvalid = 1'b1;
         if (k == 3) m_req = '0;
         #2;
      end
      nxt();
      s_rvalid = 1'b0;

      nxt();
      m_req = 3'b010;
      #2;
      check("flt_gnt", fx_gnt, 3'b010);
      check("flt_we", fx_swe, 1);
      check("flt_be", fx_sbe, 4'h3);
      check("flt_wdata", fx_swdata, 32'hB1B1);
      nxt();
      m_req = '0;
      s_rvalid = 1'b1;
      s_fault = 1'b1;
      #2;
      check("flt_rvalid", fx_rvalid, 3'b010);
      check("flt_fault", fx_fault, 3'b010);
      check("flt_tmo", fx_tmo, 0);
      nxt();
      s_rvalid = 1'b0;
      s_fault = 1'b0;

      nxt();
      m_req = 3'b100;
      #2;
      check("to_gnt", fx_gnt, 3'b100);
      for (int k = 1; k < 8; k++) begin
         nxt();
         m_req = '0;
         #2;
         check("to_wait", {fx_busy, fx_rvalid}, 4'b1000);
      end
      nxt();
      #2;
      check("to_rvalid", fx_rvalid, 3'b100);
      check("to_fault", fx_fault, 3'b100);
      check("to_evt", fx_tmo, 1);
      nxt();
      s_rvalid = 1'b1;
      #2;
      check("late_rvalid", fx_rvalid, 0);
      check("late_busy", fx_busy, 0);
      check("late_evt", fx_tmo, 0);

      nxt();
      s_rvalid = 1'b0;
      m_req = 3'b001;
      #2;
      check("sim_gnt", fx_gnt, 3'b001);
      for (int k = 1; k < 8; k++) begin
         nxt();
         m_req = '0;
      end
      nxt();
      s_rvalid = 1'b1;
      #2;
      check("sim_rvalid", fx_rvalid, 3'b001);
      check("sim_fault", fx_fault, 0);
      check("sim_evt", fx_tmo, 0);
      nxt();
      s_rvalid = 1'b0;

      nxt();
      m_req = 3'b001;
      #2;
      check("mr_gnt", fx_gnt, 3'b001);
      nxt();
      m_req = 3'b010;
      #2;
      check("mr_busy", fx_busy, 1);
      rst_n = 1'b0;
      #1;
      check("mr_rst_busy", fx_busy, 0);
      check("mr_rst_gnt", fx_gnt, 0);
      check("mr_rst_sreq", fx_sreq, 0);
      check("mr_rst_addr", fx_saddr, 0);
      nxt();
      s_rvalid = 1'b1;
      #2;
      check("mr_rst_rv", fx_rvalid, 0);
      nxt();
      rst_n = 1'b1;
      s_rvalid = 1'b0;
      #2;
      check("mr_rel_gnt", fx_gnt, 3'b010);
      check("mr_rel_addr", fx_saddr, 32'h2000);
      nxt();
      m_req = '0;
      #2;
      check("mr_owner", fx_owner, 1);
      check("mr_busy2", fx_busy, 1);
      nxt();
      s_rvalid = 1'b1;
      #2;
      check("mr_rvalid", fx_rvalid, 3'b010);
      nxt();
      s_rvalid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
